lane_overlay_axis_tx: RTL and testbench
=======================================

Name: lane_overlay_axis_tx

Overview:
- AXI4-Stream video master that produces the visualisation frame for the lane detection pipeline.
- Consumes the decision outputs: lane count, current lane, and left/right boundaries.
- Renders a synthetic RGB frame of IMG_LENGTH x IMG_WIDTH with boundary markers and a lane-fill tint.
- Streams the frame downstream to the display/VDMA path using the same video stream signalling the pipeline ingests, in the transmit direction.

Parameters:
- IMG_LENGTH, 416, lines per frame
- IMG_WIDTH, 416, pixels per line
- AXI_WIDTH, 24, tdata width (must be >= RGB_WIDTH)
- RGB_WIDTH, 24, packed R[23:16] G[15:8] B[7:0]
- LINE_HALF_WIDTH, 1, boundary marker half-thickness in pixels
- FRAME_GAP, 8, idle cycles between frames
- BG_COLOR, 24'h000000, background colour
- LINE_COLOR, 24'hFF0000, boundary marker colour
- FILL_COLOR, 24'h004000, current-lane fill colour

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- enable  in  1  level; frames are generated while high
- number_of_lanes  in  4  from decision stage
- current_lane  in  4  from decision stage
- decision_out_valid  in  1  single-cycle qualifier for the decision inputs
- current_lane_left_boundary  in  $clog2(IMG_WIDTH)+1  left boundary column
- current_lane_right_boundary  in  $clog2(IMG_WIDTH)+1  right boundary column
- m_axi_video_tdata  out  AXI_WIDTH  pixel data
- m_axi_video_tvalid  out  1  beat valid
- m_axi_video_tready  in  1  sink ready
- m_axi_video_tlast  out  1  last pixel of each line
- m_axi_video_tuser  out  1  start of frame (first pixel)
- frame_done  out  1  one-cycle pulse on the final beat handshake
- overlay_active  out  1  the current frame uses a committed decision

Behaviour:
- Reset (synchronous, active-high, any state):
  - state=IDLE, x=0, y=0.
  - Shadow and active decision registers cleared; shadow_vld=0, overlay_active=0.
  - All outputs 0, tdata=0. Reset mid-frame drops tvalid the next cycle; this is the only permitted non-handshake tvalid drop.
- Shadow capture:
  - Any cycle with decision_out_valid=1 loads the lane count, current lane and both boundaries into shadow; sets shadow_vld=1.
  - Shadow is never applied mid-frame.
- FSM:
  - IDLE: tvalid=0. Goes to LOAD when enable=1.
  - LOAD (1 cycle): if shadow_vld, active<=shadow and overlay_active<=1. x=y=0. Goes to STREAM.
    - A decision_out_valid arriving in the LOAD cycle updates shadow only; it applies to the next frame.
  - STREAM: tvalid=1.
    - Beat accepted when tvalid & tready. Then x++.
    - At x=IMG_WIDTH-1: x<=0, y++.
    - At x=IMG_WIDTH-1 and y=IMG_LENGTH-1: frame_done=1 (combinational with the handshake), go to GAP.
  - GAP: tvalid=0 for FRAME_GAP cycles. Then LOAD if enable=1, else IDLE.
    - enable deasserted during STREAM does not truncate the frame.
- Latency: tvalid rises 2 cycles after enable is first sampled high in IDLE.
- Sideband outputs:
  - tuser = (x==0 && y==0) while tvalid.
  - tlast = (x==IMG_WIDTH-1) while tvalid.
- Backpressure: while tvalid & !tready, tdata/tlast/tuser stay stable. They are derived only from registered x, y and active registers, with no combinational path from the decision inputs.
- Pixel colour (priority high to low):
  - overlay_active=0: BG_COLOR.
  - |x-L| <= LINE_HALF_WIDTH or |x-R| <= LINE_HALF_WIDTH: LINE_COLOR. Markers clip at 0 and IMG_WIDTH-1, with no wrap.
  - L < R and L < x < R: FILL_COLOR.
  - Otherwise BG_COLOR.
  - L >= R: markers only, no fill.
  - Boundaries >= IMG_WIDTH: that marker is suppressed, and fill extends only to IMG_WIDTH-1.
- Arithmetic: distance compares are done on $clog2(IMG_WIDTH)+2-bit signed values. tdata[AXI_WIDTH-1:RGB_WIDTH] = 0.
- number_of_lanes and current_lane are held in the active set for a future legend; they have no effect on pixels in this revision.

Decomposition:
- Package ld_overlay_pkg: state enum {IDLE, LOAD, STREAM, GAP}, colour constants, RGB pack helper.
- Sub-module lane_overlay_colorizer: purely combinational (x, active L/R, overlay_active) -> rgb.
- FSM, counters and handshake stay in the top.

Test Plan:
- Reset, enable=1, no decision, tready=1 constant, default params -> 173056 beats all 24'h000000. tuser on beat 0 only. tlast every 416th beat. One frame_done. Next tvalid rise after 8 gap cycles + 1 LOAD cycle.
- IMG_WIDTH=16, IMG_LENGTH=4, decision L=4, R=11 before enable -> every line: x3-5 and x10-12 FF0000, x6-9 004000, rest 000000. overlay_active=1.
- Same config, tready low 5 cycles at x=7,y=1 and randomly toggled elsewhere -> tdata/tuser/tlast stable during stalls. Exactly 64 beats, pixel order intact.
- Decision L=0, R=15 issued at beat 20 -> frame 1 unchanged. Frame 2: x0-1 and x14-15 red (clipped), x2-13 fill.
- Decision L=9, R=9 -> x8-10 red, no fill pixels anywhere.
- Assert rst at beat 20 -> tvalid=0 next cycle, overlay_active=0. After release with enable=1, beat 0 carries tuser and the frame is all background.

Source files
------------

// File: rtl/ld_overlay_pkg.sv
// Shared types, default geometry/colours and small helpers for the lane overlay video source.
package ld_overlay_pkg;

  localparam int unsigned DEF_IMG_LENGTH      = 416;
  localparam int unsigned DEF_IMG_WIDTH       = 416;
  localparam int unsigned DEF_LINE_HALF_WIDTH = 1;
  localparam int unsigned DEF_FRAME_GAP       = 8;
  localparam int unsigned RGB_W               = 24;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    STREAM = 2'd2,
    GAP    = 2'd3
  } ovl_state_e;

  function automatic logic [RGB_W-1:0] rgb_pack(input logic [7:0] r,
                                                input logic [7:0] g,
                                                input logic [7:0] b);
    return {r, g, b};
  endfunction

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam logic [RGB_W-1:0] DEF_BG_COLOR   = rgb_pack(8'h00, 8'h00, 8'h00);
  localparam logic [RGB_W-1:0] DEF_LINE_COLOR = rgb_pack(8'hFF, 8'h00, 8'h00);
  localparam logic [RGB_W-1:0] DEF_FILL_COLOR = rgb_pack(8'h00, 8'h40, 8'h00);

endpackage

// File: rtl/lane_overlay_colorizer.sv
// Pixel colour for one column: boundary markers over a current-lane tint over background.
module lane_overlay_colorizer
  import ld_overlay_pkg::*;
#(
  parameter int unsigned IMG_WIDTH       = DEF_IMG_WIDTH,
  parameter int unsigned RGB_WIDTH       = RGB_W,
  parameter int unsigned LINE_HALF_WIDTH = DEF_LINE_HALF_WIDTH,
  parameter logic [RGB_WIDTH-1:0] BG_COLOR   = DEF_BG_COLOR,
  parameter logic [RGB_WIDTH-1:0] LINE_COLOR = DEF_LINE_COLOR,
  parameter logic [RGB_WIDTH-1:0] FILL_COLOR = DEF_FILL_COLOR
) (
  input  logic [cnt_w(IMG_WIDTH)-1:0]   x_i,
  input  logic [$clog2(IMG_WIDTH):0]    left_i,
  input  logic [$clog2(IMG_WIDTH):0]    right_i,
  input  logic                          overlay_active_i,
  output logic [RGB_WIDTH-1:0]          rgb_o
);

  localparam int unsigned BW = $clog2(IMG_WIDTH) + 1;
  localparam int unsigned SW = BW + 1;
  localparam logic signed [SW-1:0] HW     = SW'(LINE_HALF_WIDTH);
  localparam logic signed [SW-1:0] HW_NEG = -HW;

  logic signed [SW-1:0] xs, ls, rs, dl, dr;
  logic                 near_l, near_r, in_fill;

  // Signed distances so markers clip at the frame edges instead of wrapping.
  always_comb begin
    xs      = $signed(SW'(x_i));
    ls      = $signed(SW'(left_i));
    rs      = $signed(SW'(right_i));
    dl      = xs - ls;
    dr      = xs - rs;
    near_l  = (left_i  < BW'(IMG_WIDTH)) && (dl >= HW_NEG) && (dl <= HW);
    near_r  = (right_i < BW'(IMG_WIDTH)) && (dr >= HW_NEG) && (dr <= HW);
    in_fill = (ls < rs) && (xs > ls) && (xs < rs);
    rgb_o   = BG_COLOR;
    if (!overlay_active_i) begin
      rgb_o = BG_COLOR;
    end else if (near_l || near_r) begin
      rgb_o = LINE_COLOR;
    end else if (in_fill) begin
      rgb_o = FILL_COLOR;
    end
  end

endmodule

// File: rtl/lane_overlay_axis_tx.sv
// AXI4-Stream video master rendering the lane overlay frame from the latest committed decision.
module lane_overlay_axis_tx
  import ld_overlay_pkg::*;
#(
  parameter int unsigned IMG_LENGTH      = DEF_IMG_LENGTH,
  parameter int unsigned IMG_WIDTH       = DEF_IMG_WIDTH,
  parameter int unsigned AXI_WIDTH       = 24,
  parameter int unsigned RGB_WIDTH       = RGB_W,
  parameter int unsigned LINE_HALF_WIDTH = DEF_LINE_HALF_WIDTH,
  parameter int unsigned FRAME_GAP       = DEF_FRAME_GAP,
  parameter logic [RGB_WIDTH-1:0] BG_COLOR   = DEF_BG_COLOR,
  parameter logic [RGB_WIDTH-1:0] LINE_COLOR = DEF_LINE_COLOR,
  parameter logic [RGB_WIDTH-1:0] FILL_COLOR = DEF_FILL_COLOR
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic [3:0]                   number_of_lanes,
  input  logic [3:0]                   current_lane,
  input  logic                         decision_out_valid,
  input  logic [$clog2(IMG_WIDTH):0]   current_lane_left_boundary,
  input  logic [$clog2(IMG_WIDTH):0]   current_lane_right_boundary,
  output logic [AXI_WIDTH-1:0]         m_axi_video_tdata,
  output logic                         m_axi_video_tvalid,
  input  logic                         m_axi_video_tready,
  output logic                         m_axi_video_tlast,
  output logic                         m_axi_video_tuser,
  output logic                         frame_done,
  output logic                         overlay_active
);

  localparam int unsigned XW       = cnt_w(IMG_WIDTH);
  localparam int unsigned YW       = cnt_w(IMG_LENGTH);
  localparam int unsigned BW       = $clog2(IMG_WIDTH) + 1;
  localparam int unsigned GW       = cnt_w(FRAME_GAP + 1);
  localparam int unsigned GAP_LAST = (FRAME_GAP > 0) ? FRAME_GAP - 1 : 0;

  ovl_state_e      state_q, state_d;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  logic [GW-1:0]   gap_q, gap_d;

  logic [3:0]      sh_lanes_q, sh_lanes_d, sh_cur_q, sh_cur_d;
  logic [BW-1:0]   sh_left_q, sh_left_d, sh_right_q, sh_right_d;
  logic            sh_vld_q, sh_vld_d;

  logic [3:0]      act_lanes_q, act_lanes_d, act_cur_q, act_cur_d;
  logic [BW-1:0]   act_left_q, act_left_d, act_right_q, act_right_d;
  logic            ovl_q, ovl_d;

  logic            x_last, y_last, beat;
  logic [RGB_WIDTH-1:0] rgb;

  assign x_last = (x_q == XW'(IMG_WIDTH - 1));
  assign y_last = (y_q == YW'(IMG_LENGTH - 1));
  assign beat   = (state_q == STREAM) && m_axi_video_tready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      gap_q       <= '0;
      sh_lanes_q  <= '0;
      sh_cur_q    <= '0;
      sh_left_q   <= '0;
      sh_right_q  <= '0;
      sh_vld_q    <= 1'b0;
      act_lanes_q <= '0;
      act_cur_q   <= '0;
      act_left_q  <= '0;
      act_right_q <= '0;
      ovl_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      gap_q       <= gap_d;
      sh_lanes_q  <= sh_lanes_d;
      sh_cur_q    <= sh_cur_d;
      sh_left_q   <= sh_left_d;
      sh_right_q  <= sh_right_d;
      sh_vld_q    <= sh_vld_d;
      act_lanes_q <= act_lanes_d;
      act_cur_q   <= act_cur_d;
      act_left_q  <= act_left_d;
      act_right_q <= act_right_d;
      ovl_q       <= ovl_d;
    end
  end

  // Decisions land in the shadow at any time; only LOAD promotes them, so frames never tear.
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    gap_d       = gap_q;
    sh_lanes_d  = sh_lanes_q;
    sh_cur_d    = sh_cur_q;
    sh_left_d   = sh_left_q;
    sh_right_d  = sh_right_q;
    sh_vld_d    = sh_vld_q;
    act_lanes_d = act_lanes_q;
    act_cur_d   = act_cur_q;
    act_left_d  = act_left_q;
    act_right_d = act_right_q;
    ovl_d       = ovl_q;
    frame_done  = 1'b0;

    if (decision_out_valid) begin
      sh_lanes_d = number_of_lanes;
      sh_cur_d   = current_lane;
      sh_left_d  = current_lane_left_boundary;
      sh_right_d = current_lane_right_boundary;
      sh_vld_d   = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (enable) state_d = LOAD;
      end
      LOAD: begin
        if (sh_vld_q) begin
          act_lanes_d = sh_lanes_q;
          act_cur_d   = sh_cur_q;
          act_left_d  = sh_left_q;
          act_right_d = sh_right_q;
          ovl_d       = 1'b1;
        end
        x_d     = '0;
        y_d     = '0;
        state_d = STREAM;
      end
      STREAM: begin
        if (beat) begin
          if (x_last) begin
            x_d = '0;
            if (y_last) begin
              y_d        = '0;
              gap_d      = '0;
              frame_done = 1'b1;
              state_d    = GAP;
            end else begin
              y_d = y_q + YW'(1);
            end
          end else begin
            x_d = x_q + XW'(1);
          end
        end
      end
      GAP: begin
        if (gap_q == GW'(GAP_LAST)) begin
          state_d = enable ? LOAD : IDLE;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  lane_overlay_colorizer #(
    .IMG_WIDTH       (IMG_WIDTH),
    .RGB_WIDTH       (RGB_WIDTH),
    .LINE_HALF_WIDTH (LINE_HALF_WIDTH),
    .BG_COLOR        (BG_COLOR),
    .LINE_COLOR      (LINE_COLOR),
    .FILL_COLOR      (FILL_COLOR)
  ) u_colorizer (
    .x_i              (x_q),
    .left_i           (act_left_q),
    .right_i          (act_right_q),
    .overlay_active_i (ovl_q),
    .rgb_o            (rgb)
  );

  // Beat payload depends only on registered position/active set, so it holds under backpressure.
  assign m_axi_video_tvalid = (state_q == STREAM);
  assign m_axi_video_tuser  = m_axi_video_tvalid && (x_q == '0) && (y_q == '0);
  assign m_axi_video_tlast  = m_axi_video_tvalid && x_last;
  assign m_axi_video_tdata  = m_axi_video_tvalid ? AXI_WIDTH'(rgb) : '0;
  assign overlay_active     = ovl_q;

  // Lane count and index are kept in the active set for a future legend.
  logic unused_legend;
  assign unused_legend = ^{act_lanes_q, act_cur_q};

endmodule

// File: tb/tb_lane_overlay_axis_tx.sv
// Scoreboard bench for lane_overlay_axis_tx on a 16x4 frame with random backpressure.
module tb_lane_overlay_axis_tx;

  localparam int W    = 16;
  localparam int H    = 4;
  localparam int GAPC = 8;
  localparam int NC   = 7;
  localparam logic [23:0] C_LINE = 24'hFF0000;
  localparam logic [23:0] C_FILL = 24'h004000;
  localparam logic [23:0] C_BG   = 24'h000000;

  logic        clk = 1'b0;
  logic        rst, enable, decision_out_valid;
  logic [3:0]  number_of_lanes, current_lane;
  logic [4:0]  left_b, right_b;
  logic [23:0] m_axi_video_tdata;
  logic        m_axi_video_tvalid, m_axi_video_tready, m_axi_video_tlast, m_axi_video_tuser;
  logic        frame_done, overlay_active;

  always #5 clk = ~clk;

  lane_overlay_axis_tx #(
    .IMG_LENGTH (H),
    .IMG_WIDTH  (W),
    .FRAME_GAP  (GAPC)
  ) dut (
    .clk                         (clk),
    .rst                         (rst),
    .enable                      (enable),
    .number_of_lanes             (number_of_lanes),
    .current_lane                (current_lane),
    .decision_out_valid          (decision_out_valid),
    .current_lane_left_boundary  (left_b),
    .current_lane_right_boundary (right_b),
    .m_axi_video_tdata           (m_axi_video_tdata),
    .m_axi_video_tvalid          (m_axi_video_tvalid),
    .m_axi_video_tready          (m_axi_video_tready),
    .m_axi_video_tlast           (m_axi_video_tlast),
    .m_axi_video_tuser           (m_axi_video_tuser),
    .frame_done                  (frame_done),
    .overlay_active              (overlay_active)
  );

  typedef struct {
    logic [23:0] data;
    logic        user;
    logic        last;
    logic        done;
    logic        ovl;
  } exp_t;

  typedef struct {
    logic [4:0] l;
    logic [4:0] r;
    string      pat;
  } case_t;

  exp_t  sb_q[$];
  exp_t  mon_e;
  case_t cases[NC];

  int checks = 0;
  int failures = 0;
  bit mon_en = 0;
  int beat_in_frame = 0;
  int frames_seen = 0;
  int dut_done_cnt = 0;
  bit held_v = 0;
  logic [23:0] h_data;
  logic h_user, h_last;
  bit gap_meas = 0;
  int low_cnt = 0;
  bit stall_armed = 1;
  int stall_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s frame=%0d beat=%0d actual=%0h expected=%0h",
               name, frames_seen, beat_in_frame, act, exp);
    end
  endtask

  task automatic push_frame(input string pat, input logic ovl);
    exp_t e;
    byte  c;
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        e.data = C_BG;
        if (ovl) begin
          c = pat[x];
          if (c == "R") e.data = C_LINE;
          else if (c == "F") e.data = C_FILL;
        end
        e.user = (x == 0) && (y == 0);
        e.last = (x == W - 1);
        e.done = (x == W - 1) && (y == H - 1);
        e.ovl  = ovl;
        sb_q.push_back(e);
      end
    end
  endtask

  // Output monitor: sampled mid-cycle; a beat is taken when tvalid&tready are both seen.
  always @(negedge clk) begin
    if (mon_en) begin
      if (frame_done) dut_done_cnt++;
      if (m_axi_video_tvalid) begin
        if (held_v) begin
          check("stall_tdata", 32'(m_axi_video_tdata), 32'(h_data));
          check("stall_tuser", 32'(m_axi_video_tuser), 32'(h_user));
          check("stall_tlast", 32'(m_axi_video_tlast), 32'(h_last));
        end
        if (gap_meas) begin
          check("gap_low_cycles", 32'(low_cnt), 32'(GAPC + 1));
          gap_meas = 0;
        end
        if (m_axi_video_tready) begin
          held_v = 0;
          if (sb_q.size() == 0) begin
            check("unexpected_beat", 32'(1), 32'(0));
          end else begin
            mon_e = sb_q.pop_front();
            check("beat_tdata", 32'(m_axi_video_tdata), 32'(mon_e.data));
            check("beat_tuser", 32'(m_axi_video_tuser), 32'(mon_e.user));
            check("beat_tlast", 32'(m_axi_video_tlast), 32'(mon_e.last));
            check("beat_frame_done", 32'(frame_done), 32'(mon_e.done));
            check("beat_overlay_active", 32'(overlay_active), 32'(mon_e.ovl));
            if (mon_e.done) begin
              frames_seen++;
              beat_in_frame = 0;
              gap_meas = 1;
              low_cnt = 0;
            end else begin
              beat_in_frame++;
            end
          end
        end else begin
          check("stall_frame_done", 32'(frame_done), 32'(0));
          held_v = 1;
          h_data = m_axi_video_tdata;
          h_user = m_axi_video_tuser;
          h_last = m_axi_video_tlast;
        end
      end else begin
        if (held_v) check("tvalid_held", 32'(m_axi_video_tvalid), 32'(1));
        held_v = 0;
        check("idle_frame_done", 32'(frame_done), 32'(0));
        if (gap_meas) low_cnt++;
      end
    end
  end

  // Sink ready: random, plus one forced 5-cycle stall on x=7,y=1 of the first overlay frame.
  initial begin
    m_axi_video_tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (stall_armed && frames_seen == 1 && beat_in_frame == W + 7) begin
        stall_cnt = 5;
        stall_armed = 0;
      end
      if (stall_cnt > 0) begin
        m_axi_video_tready = 1'b0;
        stall_cnt--;
      end else begin
        m_axi_video_tready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  task automatic send_decision(input logic [4:0] l, input logic [4:0] r);
    decision_out_valid = 1'b1;
    left_b = l;
    right_b = r;
    number_of_lanes = 4'd3;
    current_lane = 4'd1;
    @(posedge clk);
    #1;
    decision_out_valid = 1'b0;
  endtask

  task automatic wait_beat(input int n);
    int t = 0;
    while (beat_in_frame < n && t < 3000) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("wait_beat_timeout", 32'(beat_in_frame >= n), 32'(1));
  endtask

  task automatic wait_frames(input int n);
    int t = 0;
    while (frames_seen < n && t < 3000) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("wait_frame_timeout", 32'(frames_seen >= n), 32'(1));
  endtask

  initial begin
    cases[0] = '{l: 5'd4,  r: 5'd11, pat: "BBBRRRFFFFRRRBBB"};
    cases[1] = '{l: 5'd0,  r: 5'd15, pat: "RRFFFFFFFFFFFFRR"};
    cases[2] = '{l: 5'd9,  r: 5'd9,  pat: "BBBBBBBBRRRBBBBB"};
    cases[3] = '{l: 5'd11, r: 5'd4,  pat: "BBBRRRBBBBRRRBBB"};
    cases[4] = '{l: 5'd5,  r: 5'd20, pat: "BBBBRRRFFFFFFFFF"};
    cases[5] = '{l: 5'd15, r: 5'd0,  pat: "RRBBBBBBBBBBBBRR"};
    cases[6] = '{l: 5'd16, r: 5'd2,  pat: "BRRRBBBBBBBBBBBB"};

    rst = 1'b1;
    enable = 1'b0;
    decision_out_valid = 1'b0;
    number_of_lanes = 4'd0;
    current_lane = 4'd0;
    left_b = 5'd0;
    right_b = 5'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", 32'(m_axi_video_tvalid), 32'(0));
    check("rst_tuser", 32'(m_axi_video_tuser), 32'(0));
    check("rst_tlast", 32'(m_axi_video_tlast), 32'(0));
    check("rst_tdata", 32'(m_axi_video_tdata), 32'(0));
    check("rst_frame_done", 32'(frame_done), 32'(0));
    check("rst_overlay_active", 32'(overlay_active), 32'(0));

    rst = 1'b0;
    @(posedge clk);
    #1;
    check("idle_tvalid", 32'(m_axi_video_tvalid), 32'(0));

    push_frame("", 1'b0);
    mon_en = 1;
    enable = 1'b1;
    @(posedge clk);
    #1;
    check("load_tvalid", 32'(m_axi_video_tvalid), 32'(0));
    @(posedge clk);
    #1;
    check("latency_tvalid", 32'(m_axi_video_tvalid), 32'(1));
    check("latency_tuser", 32'(m_axi_video_tuser), 32'(1));

    // Each decision is issued mid-frame and must only show up in the following frame.
    for (int k = 0; k < NC; k++) begin
      wait_beat(20);
      send_decision(cases[k].l, cases[k].r);
      push_frame(cases[k].pat, 1'b1);
      wait_frames(k + 1);
    end

    wait_beat(20);
    mon_en = 0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_tvalid", 32'(m_axi_video_tvalid), 32'(0));
    check("midrst_overlay_active", 32'(overlay_active), 32'(0));
    check("midrst_tuser", 32'(m_axi_video_tuser), 32'(0));
    check("midrst_tlast", 32'(m_axi_video_tlast), 32'(0));
    check("midrst_tdata", 32'(m_axi_video_tdata), 32'(0));
    sb_q.delete();
    beat_in_frame = 0;
    held_v = 0;
    gap_meas = 0;
    push_frame("", 1'b0);
    rst = 1'b0;
    mon_en = 1;
    wait_frames(NC + 1);
    mon_en = 0;
    enable = 1'b0;

    check("scoreboard_empty", 32'(sb_q.size()), 32'(0));
    check("forced_stall_hit", 32'(stall_armed), 32'(0));
    check("frame_done_pulses", 32'(dut_done_cnt), 32'(NC + 1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
